// File: rtl/led_pkg.sv
// Shared constants for the RGB LED sequencer: mode and envelope encodings,
// the six-entry colour palette and palette index helpers.
package led_pkg;

    localparam int          IDX_W = 3;
    localparam int unsigned PAL_N = 6;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_CYCLE   = 2'd3
    } mode_e;

    typedef enum logic {
        ENV_UP   = 1'b0,
        ENV_DOWN = 1'b1
    } env_state_e;

    localparam logic [23:0] COL_RED    = 24'hdc143c;
    localparam logic [23:0] COL_ORANGE = 24'hff4500;
    localparam logic [23:0] COL_YELLOW = 24'hffd700;
    localparam logic [23:0] COL_BLUE   = 24'h1e90ff;
    localparam logic [23:0] COL_INDIGO = 24'h0000cd;
    localparam logic [23:0] COL_PURPLE = 24'h9400d3;
    localparam logic [23:0] COL_WHITE  = 24'hffffff;

    function automatic logic [23:0] palette_colour(input logic [IDX_W-1:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_RED;
            3'd1:    c = COL_ORANGE;
            3'd2:    c = COL_YELLOW;
            3'd3:    c = COL_BLUE;
            3'd4:    c = COL_INDIGO;
            3'd5:    c = COL_PURPLE;
            default: c = COL_RED;
        endcase
        return c;
    endfunction

    // Palette index for an LED offset from the base index, wrapping at PAL_N.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] idx,
                                                 input int unsigned       k);
        int unsigned s;
        s = (32'(idx) + k) % PAL_N;
        return IDX_W'(s);
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One RGB LED: scales a 24-bit colour by a brightness level and drives three
// PWM outputs. Duty registers reload only at frame start to avoid glitches.
module rgb_pwm_chan #(
    parameter int PWM_W = 8,
    parameter int BRT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             frame_start,
    input  logic [23:0]      colour,
    input  logic [BRT_W-1:0] b,
    output logic [2:0]       rgb
);

    localparam logic [BRT_W-1:0] BRT_MAX = '1;

    // Full brightness passes the byte through untouched; the result keeps the
    // PWM_W most significant bits of the scaled byte.
    function automatic logic [PWM_W-1:0] scale(input logic [7:0]       c,
                                               input logic [BRT_W-1:0] bb);
        logic [BRT_W+7:0] prod;
        logic [7:0]       e8;
        logic [31:0]      wide;
        prod = {{BRT_W{1'b0}}, c} * {8'd0, bb};
        if (bb == BRT_MAX) e8 = c;
        else               e8 = prod[BRT_W+7:BRT_W];
        wide = {e8, 24'd0} >> (32 - PWM_W);
        return wide[PWM_W-1:0];
    endfunction

    logic [PWM_W-1:0] eff_q   [3];
    logic [PWM_W-1:0] eff_d   [3];
    logic [PWM_W-1:0] eff_use [3];

    // Index 2 is red (colour[23:16], rgb[2]), 0 is blue.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eff_d[i]   = scale(colour[8*i+7 -: 8], b);
            eff_use[i] = frame_start ? eff_d[i] : eff_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) eff_q[i] <= '0;
            rgb <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (frame_start) eff_q[i] <= eff_d[i];
                rgb[i] <= enable && (pwm_cnt < eff_use[i]);
            end
        end
    end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Multi-LED RGB sequencer: breathing envelope times palette colour, per-channel
// PWM with a rainbow offset per LED. Define RGB_LED_GAMMA_EN for squared brightness.
module rgb_led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LED      = 2,
    parameter int PWM_W        = 8,
    parameter int BRT_W        = 8,
    parameter int TICK_DIV     = 100000,
    parameter int HOLD_BREATHS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 btn,
    output logic [3*NUM_LED-1:0] rgb,
    output logic [IDX_W-1:0]     colour_idx,
    output logic [BRT_W-1:0]     brightness,
    output logic                 breath_done,
    output env_state_e           env_state
);

    localparam int               PRE_W   = $clog2(TICK_DIV);
    localparam int               HB_W    = (HOLD_BREATHS > 1) ? $clog2(HOLD_BREATHS) : 1;
    localparam logic [BRT_W-1:0] BRT_MAX = '1;

    mode_e            mode_m;
    logic [PRE_W-1:0] presc_q;
    logic [PWM_W-1:0] pwm_q;
    logic             tick;
    logic             frame_start;
    logic             out_on;
    logic [BRT_W-1:0] b_lvl;

    env_state_e       state_q, state_d;
    logic [BRT_W-1:0] brt_q, brt_d;
    logic [HB_W-1:0]  hb_q, hb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    assign mode_m      = mode_e'(mode);
    assign tick        = en && (presc_q == PRE_W'(TICK_DIV - 1));
    assign frame_start = en && (pwm_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pwm_q   <= '0;
        end else if (en) begin
            presc_q <= (presc_q == PRE_W'(TICK_DIV - 1)) ? '0 : presc_q + PRE_W'(1);
            pwm_q   <= pwm_q + PWM_W'(1);
        end
    end

    // Envelope state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENV_UP;
            brt_q   <= '0;
            hb_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            brt_q   <= brt_d;
            hb_q    <= hb_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Envelope next state: direction flips on the step that reaches an end.
    always_comb begin
        state_d = state_q;
        brt_d   = brt_q;
        hb_d    = hb_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (en) begin
            unique case (mode_m)
                MODE_OFF: begin
                    state_d = ENV_UP;
                    brt_d   = '0;
                end
                MODE_STATIC: begin
                    state_d = ENV_UP;
                    brt_d   = BRT_MAX;
                end
                default: begin
                    if (tick) begin
                        case (state_q)
                            ENV_UP: begin
                                if (brt_q == BRT_MAX) begin
                                    state_d = ENV_DOWN;
                                end else begin
                                    brt_d = brt_q + BRT_W'(1);
                                    if (brt_q == BRT_MAX - BRT_W'(1)) state_d = ENV_DOWN;
                                end
                            end
                            ENV_DOWN: begin
                                if (brt_q == '0) begin
                                    state_d = ENV_UP;
                                end else begin
                                    brt_d = brt_q - BRT_W'(1);
                                    if (brt_q == BRT_W'(1)) begin
                                        state_d = ENV_UP;
                                        done_d  = 1'b1;
                                        if (hb_q == HB_W'(HOLD_BREATHS - 1)) begin
                                            hb_d = '0;
                                            if (mode_m == MODE_CYCLE)
                                                idx_d = (idx_q == IDX_W'(PAL_N - 1)) ? '0 : idx_q + IDX_W'(1);
                                        end else begin
                                            hb_d = hb_q + HB_W'(1);
                                        end
                                    end
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef RGB_LED_GAMMA_EN
    logic [2*BRT_W-1:0] b_sq;
`endif

    // Outputs and the brightness level fed to the PWM channels
    always_comb begin
        out_on = en && (mode_m != MODE_OFF);
`ifdef RGB_LED_GAMMA_EN
        b_sq  = {{BRT_W{1'b0}}, brt_q} * {{BRT_W{1'b0}}, brt_q};
        b_lvl = (brt_q == BRT_MAX) ? BRT_MAX : b_sq[2*BRT_W-1:BRT_W];
`else
        b_lvl = brt_q;
`endif
        colour_idx  = idx_q;
        brightness  = brt_q;
        breath_done = done_q;
        env_state   = state_q;
    end

    for (genvar k = 0; k < NUM_LED; k++) begin : g_led
        logic [23:0] led_col;
        assign led_col = btn ? COL_WHITE : palette_colour(idx_add(idx_q, 32'(k)));

        rgb_pwm_chan #(
            .PWM_W (PWM_W),
            .BRT_W (BRT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (out_on),
            .pwm_cnt     (pwm_q),
            .frame_start (frame_start),
            .colour      (led_col),
            .b           (b_lvl),
            .rgb         (rgb[3*k +: 3])
        );
    end

endmodule
